oven_plant: RTL and testbench

OVEN_PLANT -- requirements
Module: oven_plant

---
 rtl/oven_plant_if.sv | 29 ++
 rtl/oven_plant.sv | 111 +++++++++++
 tb/tb_oven_plant.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/oven_plant_if.sv
// Plant-side bus between the oven controller model and the thermal/timer plant.
//   heater_on  : heater command from the controller (controller -> plant)
//   run        : cook-in-progress from the controller (controller -> plant)
//   temp       : modelled oven temperature, 8 bits (plant -> controller)
//   timer      : elapsed run time in timer units, 4 bits (plant -> controller)
//   tick       : one-cycle pulse when temp/timer have just been updated
//   at_max     : temp is at the ceiling
//   at_ambient : temp is at the ambient floor
interface oven_plant_if;
   logic       heater_on;
   logic       run;
   logic [7:0] temp;
   logic [3:0] timer;
   logic       tick;
   logic       at_max;
   logic       at_ambient;

   // controller side
   modport master (
      output heater_on, run,
      input  temp, timer, tick, at_max, at_ambient
   );

   // plant side
   modport slave (
      input  heater_on, run,
      output temp, timer, tick, at_max, at_ambient
   );
endinterface

// File: rtl/oven_plant.sv
// Closed-loop thermal/timer plant for the oven controller.
// Every TICK_DIV clock cycles the plant heats or cools the modelled temperature
// according to heater_on, and advances a run timer (in units of TIMER_DIV ticks)
// while run is high. A rising edge of run restarts the timer.
// Ports:
//   clk : sole clock, all state changes on its rising edge
//   rst : synchronous active-high reset
//   bus : oven_plant_if.slave (heater_on, run in; temp, timer, tick, at_max, at_ambient out)
module oven_plant #(
   parameter int unsigned TICK_DIV  = 1000,
   parameter int unsigned TIMER_DIV = 60,
   parameter int unsigned HEAT_STEP = 2,
   parameter int unsigned COOL_STEP = 1,
   parameter int unsigned AMBIENT   = 25,
   parameter int unsigned TEMP_MAX  = 250
) (
   input logic          clk,
   input logic          rst,
   oven_plant_if.slave  bus
);

   localparam int unsigned PRE_W = $clog2(TICK_DIV);
   localparam int unsigned SUB_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TIMER_DIV - 1);

   localparam logic [7:0] AMB8   = 8'(AMBIENT);
   localparam logic [7:0] MAX8   = 8'(TEMP_MAX);
   localparam logic [7:0] COOL8  = 8'(COOL_STEP);
   localparam logic [8:0] MAX9   = 9'(TEMP_MAX);
   localparam logic [8:0] HEAT9  = 9'(HEAT_STEP);
   // Lowest temperature from which a full cool step stays at or above ambient
   localparam logic [8:0] FLOOR9 = 9'(AMBIENT + COOL_STEP);

   logic [PRE_W-1:0] prescaler;
   logic [SUB_W-1:0] sub_cnt;
   logic [7:0]       temp_q;
   logic [3:0]       timer_q;
   logic             tick_q;
   logic             at_max_q;
   logic             at_amb_q;
   logic             run_q;

   logic             tick_cycle_c;
   logic             run_start_c;
   logic [8:0]       heat_sum_c;
   logic [7:0]       temp_nxt_c;

   assign tick_cycle_c = (prescaler == PRE_LAST);
   assign run_start_c  = bus.run & ~run_q;

   // Next temperature: 9-bit heat sum clipped at the ceiling, cooling clipped at ambient
   always_comb begin
      heat_sum_c = {1'b0, temp_q} + HEAT9;
      temp_nxt_c = temp_q;
      if (bus.heater_on) begin
         temp_nxt_c = (heat_sum_c > MAX9) ? MAX8 : heat_sum_c[7:0];
      end else if ({1'b0, temp_q} >= FLOOR9) begin
         temp_nxt_c = temp_q - COOL8;
      end else begin
         temp_nxt_c = AMB8;
      end
   end

   // Prescaler, thermal state, run timer and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler <= '0;
         sub_cnt   <= '0;
         temp_q    <= AMB8;
         timer_q   <= 4'd0;
         tick_q    <= 1'b0;
         at_max_q  <= 1'b0;
         at_amb_q  <= 1'b1;
         run_q     <= 1'b0;
      end else begin
         run_q     <= bus.run;
         tick_q    <= tick_cycle_c;
         prescaler <= tick_cycle_c ? '0 : prescaler + 1'b1;

         if (tick_cycle_c) begin
            temp_q   <= temp_nxt_c;
            at_max_q <= (temp_nxt_c == MAX8);
            at_amb_q <= (temp_nxt_c == AMB8);
         end

         // A run start wins over a coincident tick's timer advance
         if (run_start_c) begin
            sub_cnt <= '0;
            timer_q <= 4'd0;
         end else if (tick_cycle_c && bus.run) begin
            if (sub_cnt == SUB_LAST) begin
               sub_cnt <= '0;
               if (timer_q != 4'hF) begin
                  timer_q <= timer_q + 4'd1;
               end
            end else begin
               sub_cnt <= sub_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.temp       = temp_q;
   assign bus.timer      = timer_q;
   assign bus.tick       = tick_q;
   assign bus.at_max     = at_max_q;
   assign bus.at_ambient = at_amb_q;

endmodule

// File: tb/tb_oven_plant.sv
// Directed self-checking bench for oven_plant with TICK_DIV=4, TIMER_DIV=3.
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
module tb_oven_plant;

   localparam int unsigned TD = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   n;

   oven_plant_if bus ();

   oven_plant #(
      .TICK_DIV  (TD),
      .TIMER_DIV (3),
      .HEAT_STEP (2),
      .COOL_STEP (1),
      .AMBIENT   (25),
      .TEMP_MAX  (250)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance edge by edge until tick is seen; nticks = edges consumed
   task automatic wait_tick(output int nedges);
      nedges = 0;
      do begin
         @(posedge clk);
         #1;
         nedges++;
      end while (!bus.tick && nedges < 2 * TD);
      if (!bus.tick) check("tick_timeout", 0, 1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      bus.heater_on = 1'b0;
      bus.run       = 1'b0;
      rst           = 1'b1;
      step();
      step();

      // reset state
      check("rst_temp", int'(bus.temp), 25);
      check("rst_timer", int'(bus.timer), 0);
      check("rst_tick", int'(bus.tick), 0);
      check("rst_at_max", int'(bus.at_max), 0);
      check("rst_at_amb", int'(bus.at_ambient), 1);

      // heating from ambient, tick period
      rst = 1'b0;
      bus.heater_on = 1'b1;
      wait_tick(n);
      check("first_tick_latency", n, 4);
      check("heat_temp0", int'(bus.temp), 27);
      check("heat_at_amb", int'(bus.at_ambient), 0);
      for (int k = 1; k <= 4; k++) begin
         wait_tick(n);
         check("heat_period", n, 4);
         check("heat_temp", int'(bus.temp), 27 + 2 * k);
      end
      step();
      check("tick_width", int'(bus.tick), 0);
      wait_tick(n);
      check("tick_phase", n, 3);
      check("heat_temp37", int'(bus.temp), 37);

      // ceiling saturation
      for (int k = 0; k < 106; k++) wait_tick(n);
      check("pre_max_temp", int'(bus.temp), 249);
      check("pre_max_flag", int'(bus.at_max), 0);
      wait_tick(n);
      check("max_temp", int'(bus.temp), 250);
      check("max_flag", int'(bus.at_max), 1);
      wait_tick(n);
      check("max_hold_temp", int'(bus.temp), 250);
      check("max_hold_flag", int'(bus.at_max), 1);

      // cooling to ambient; heater glitch between ticks is ignored
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_tick(n);
      check("cool_start", int'(bus.temp), 27);
      bus.heater_on = 1'b0;
      step();
      bus.heater_on = 1'b1;
      step();
      bus.heater_on = 1'b0;
      wait_tick(n);
      check("cool_glitch_phase", n, 2);
      check("cool_26", int'(bus.temp), 26);
      check("cool_26_amb", int'(bus.at_ambient), 0);
      wait_tick(n);
      check("cool_25", int'(bus.temp), 25);
      check("cool_25_amb", int'(bus.at_ambient), 1);
      for (int k = 0; k < 2; k++) begin
         wait_tick(n);
         check("amb_hold", int'(bus.temp), 25);
         check("amb_hold_flag", int'(bus.at_ambient), 1);
      end

      // run timer
      bus.run = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         wait_tick(n);
         if (k == 3) check("timer_3t", int'(bus.timer), 1);
      end
      check("timer_9t", int'(bus.timer), 3);
      bus.run = 1'b0;
      for (int k = 0; k < 6; k++) wait_tick(n);
      check("timer_hold", int'(bus.timer), 3);
      bus.run = 1'b1;
      step();
      check("timer_restart", int'(bus.timer), 0);

      // timer saturation
      for (int k = 1; k <= 60; k++) begin
         wait_tick(n);
         if (k == 42) check("timer_14", int'(bus.timer), 14);
         if (k == 45) check("timer_15", int'(bus.timer), 15);
      end
      check("timer_sat", int'(bus.timer), 15);

      // run rising inside a tick cycle: timer clears, temp still updates
      bus.run = 1'b0;
      wait_tick(n);
      check("timer_idle", int'(bus.timer), 15);
      step();
      step();
      step();
      check("pre_tick_cycle", int'(bus.tick), 0);
      bus.run = 1'b1;
      bus.heater_on = 1'b1;
      step();
      check("start_tick", int'(bus.tick), 1);
      check("start_timer", int'(bus.timer), 0);
      check("start_temp", int'(bus.temp), 27);
      wait_tick(n);
      wait_tick(n);
      check("start_sub_2", int'(bus.timer), 0);
      wait_tick(n);
      check("start_sub_3", int'(bus.timer), 1);
      check("start_temp33", int'(bus.temp), 33);

      // reset mid-heating
      for (int k = 0; k < 24; k++) wait_tick(n);
      check("temp_81", int'(bus.temp), 81);
      bus.heater_on = 1'b0;
      wait_tick(n);
      check("temp_80", int'(bus.temp), 80);
      check("timer_9", int'(bus.timer), 9);
      bus.heater_on = 1'b1;
      step();
      rst = 1'b1;
      step();
      check("mid_rst_temp", int'(bus.temp), 25);
      check("mid_rst_timer", int'(bus.timer), 0);
      check("mid_rst_tick", int'(bus.tick), 0);
      check("mid_rst_amb", int'(bus.at_ambient), 1);
      rst = 1'b0;
      wait_tick(n);
      check("mid_rst_latency", n, 4);
      check("mid_rst_heat", int'(bus.temp), 27);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
